// File: rtl/dac_12b.sv
// dac_12b: 12-bit zero-order-hold DAC model.
// A free-running tick counter divides clk by TICK_DIV while en is high.
// On each tick the input code is captured into D_reg and held until the
// next tick. A_out is a real-valued voltage model of the held code and is
// for simulation only; everything else is synthesizable.
module dac_12b #(
   parameter real VREF     = 3.3,
   parameter int  TICK_DIV = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [11:0] I_data,
   output logic        tick,
   output logic [11:0] D_reg,
   output real         A_out
);

   // Last count value of a conversion period (0 when TICK_DIV is 1,
   // which makes tick follow en directly).
   localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

   logic [15:0] count;

   // Tick counter: advances only while enabled, wraps after LAST, and
   // freezes in place when en drops so the period resumes where it stopped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         if (count == LAST) begin
            count <= '0;
         end else begin
            count <= count + 16'd1;
         end
      end
   end

   // Conversion strobe: end of period, gated by en so it is never high
   // while the counter is stalled.
   always_comb begin
      tick = en && (count == LAST);
   end

   // Zero-order hold: capture the input code only on a tick edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         D_reg <= '0;
      end else if (tick) begin
         D_reg <= I_data;
      end
   end

   // Analog model: one LSB is VREF/4096, so full-scale code 4095 sits one
   // LSB below VREF. Follows D_reg with no extra latency.
   assign A_out = real'(D_reg) * VREF / 4096.0;

endmodule

// File: tb/tb_dac_12b.sv
// tb_dac_12b: directed bench for dac_12b (TICK_DIV=10 and TICK_DIV=1).
module tb_dac_12b;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [11:0] data;
   logic        tick;
   logic [11:0] d_reg;
   real         a_out;

   logic        en1;
   logic [11:0] data1;
   logic        tick1;
   logic [11:0] d_reg1;
   real         a_out1;

   int          total;
   int          bad;
   int          n;
   longint      t_prev;
   logic [11:0] exp_d1;
   logic [11:0] exp_q[$];
   logic [11:0] code;

   int          v_en[6] = '{1, 0, 1, 1, 0, 1};
   int          v_d[6]  = '{100, 200, 300, 4095, 5, 0};

   dac_12b #(.VREF(3.3), .TICK_DIV(10)) dut (
      .clk(clk), .rst(rst), .en(en), .I_data(data),
      .tick(tick), .D_reg(d_reg), .A_out(a_out)
   );

   dac_12b #(.VREF(3.3), .TICK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .en(en1), .I_data(data1),
      .tick(tick1), .D_reg(d_reg1), .A_out(a_out1)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_real(input string tag, input real obs, input real exp);
      total++;
      assert ((obs - exp) < 1.0e-9 && (exp - obs) < 1.0e-9) else begin
         bad++;
         $error("FAIL %s: observed=%.13f expected=%.13f", tag, obs, exp);
      end
   endtask

   // Steps until tick is seen; n is the number of edges taken, -1 on timeout.
   task automatic wait_tick(output int cnt);
      cnt = -1;
      for (int i = 1; i <= 200; i++) begin
         step();
         if (tick === 1'b1) begin
            cnt = i;
            break;
         end
      end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      exp_d1 = 12'd0;
      rst    = 1'b1;
      en     = 1'b0;
      data   = 12'd0;
      en1    = 1'b0;
      data1  = 12'd0;

      // Reset state
      repeat (3) step();
      chk("rst_count", dut.count, 0);
      chk("rst_dreg", d_reg, 0);
      chk("rst_tick", tick, 0);
      chk_real("rst_aout", a_out, 0.0);
      chk("rst_dreg1", d_reg1, 0);

      // Release, first tick loads on the 10th edge after release
      rst  = 1'b0;
      en   = 1'b1;
      data = 12'd4000;
      wait_tick(n);
      chk("first_tick_edges", n, 9);
      t_prev = $time;
      step();
      chk("load_4000", d_reg, 4000);
      chk_real("aout_4000", a_out, 3.22265625);

      // Step 1000 then 500 between ticks
      data = 12'd1000;
      wait_tick(n);
      chk("gap_1000", n, 9);
      chk("period_1000", $time - t_prev, 100);
      t_prev = $time;
      step();
      chk("load_1000", d_reg, 1000);
      chk_real("aout_1000", a_out, 0.8056640625);
      repeat (3) step();
      data = 12'd500;
      repeat (2) step();
      chk("hold_1000", d_reg, 1000);
      chk_real("hold_aout_1000", a_out, 0.8056640625);
      wait_tick(n);
      chk("gap_500", n, 4);
      chk("period_500", $time - t_prev, 100);
      t_prev = $time;
      step();
      chk("load_500", d_reg, 500);
      chk_real("aout_500", a_out, 0.40283203125);

      // en low for 37 cycles mid-period
      repeat (4) step();
      en   = 1'b0;
      data = 12'd4000;
      for (int i = 0; i < 37; i++) begin
         step();
         chk("tick_while_en_low", tick, 0);
      end
      chk("frozen_count", dut.count, 4);
      chk("hold_500", d_reg, 500);
      en = 1'b1;
      wait_tick(n);
      chk("resume_gap", n, 5);
      step();
      chk("load_after_resume", d_reg, 4000);

      // Asynchronous reset off-edge at count=6
      repeat (6) step();
      chk("count_at_6", dut.count, 6);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_dreg", d_reg, 0);
      chk_real("async_rst_aout", a_out, 0.0);
      chk("async_rst_count", dut.count, 0);
      chk("async_rst_tick", tick, 0);
      repeat (2) step();
      rst = 1'b0;
      wait_tick(n);
      chk("post_rst_gap", n, 9);
      step();
      chk("post_rst_load", d_reg, 4000);

      // Full scale and zero codes
      data = 12'd4095;
      wait_tick(n);
      chk("gap_4095", n, 9);
      step();
      chk("load_4095", d_reg, 4095);
      chk_real("aout_4095", a_out, 3.2991943359375);
      data = 12'd0;
      wait_tick(n);
      chk("gap_0", n, 9);
      t_prev = $time;
      step();
      chk("load_0", d_reg, 0);
      chk_real("aout_0", a_out, 0.0);

      // Long run: 4000 periods (400k time units) with random codes and
      // a decoy code applied early in every period
      for (int k = 0; k < 4000; k++) begin
         data = 12'($urandom_range(0, 4095));
         repeat (3) step();
         code = 12'($urandom_range(0, 4095));
         data = code;
         exp_q.push_back(code);
         wait_tick(n);
         chk("run_gap", n, 6);
         chk("run_period", $time - t_prev, 100);
         t_prev = $time;
         step();
         if (exp_q.size() > 0) begin
            code = exp_q.pop_front();
            chk("run_dreg", d_reg, code);
            chk_real("run_aout", a_out, real'(code) * 3.3 / 4096.0);
         end
      end

      // TICK_DIV=1 instance: tick mirrors en, loads on every enabled edge
      for (int i = 0; i < 6; i++) begin
         en1   = (v_en[i] != 0);
         data1 = 12'(v_d[i]);
         #1;
         chk("tick1_mirror", tick1, v_en[i]);
         step();
         if (v_en[i] != 0) exp_d1 = 12'(v_d[i]);
         chk("dreg1", d_reg1, exp_d1);
         chk_real("aout1", a_out1, real'(exp_d1) * 3.3 / 4096.0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
